mult_arbiter: RTL
=================

Name: mult_arbiter

Overview:
Round-robin arbiter and sequencer that shares one sequential shift-and-add multiplier unit between N_REQ requesters. It accepts operand pairs over a valid/ready handshake and issues a one-cycle start to the multiplier. It waits for the multiplier's done pulse, guarded by a watchdog, and returns the product tagged with the requester ID. It sits between the requesting datapath blocks and the single multiplier instance.

Parameters:
N_REQ, 4, number of requesters (2..16)
WIDTH, 32, operand width in bits; product width is 2*WIDTH
TIMEOUT, 40, maximum cycles spent in WAIT before aborting (must exceed the multiplier's worst-case latency)
ID_W, $clog2(N_REQ), width of the requester ID

Ports:
i_clk  input  1  clock; all logic on the rising edge
i_rst_n  input  1  asynchronous active-low reset
i_req_valid  input  N_REQ  per-requester request valid
o_req_ready  output  N_REQ  per-requester accept; one-hot or zero
i_req_a  input  N_REQ*WIDTH  packed operand A; requester k uses bits [k*WIDTH +: WIDTH]
i_req_b  input  N_REQ*WIDTH  packed operand B, same packing as i_req_a
o_mul_start  output  1  one-cycle start pulse to the multiplier
o_mul_a  output  WIDTH  operand A to the multiplier, registered
o_mul_b  output  WIDTH  operand B to the multiplier, registered
i_mul_done  input  1  multiplier result-valid pulse
i_mul_result  input  2*WIDTH  multiplier product
o_rsp_valid  output  1  response valid
o_rsp_id  output  ID_W  ID of the requester being answered
o_rsp_result  output  2*WIDTH  product; 0 on error
o_rsp_error  output  1  watchdog expired; result invalid
i_rsp_ready  input  1  consumer accepts the response
o_busy  output  1  high in every state except IDLE

Behaviour:
Reset (asynchronous, i_rst_n=0):
- State returns to IDLE immediately.
- All registered outputs go to 0, the round-robin pointer goes to 0, and the watchdog counter goes to 0.
- Reset mid-operation abandons the in-flight request: no response is produced, and the multiplier is not notified.

The FSM has four states: IDLE, ISSUE, WAIT, RESP.

IDLE:
- The grant is the first k with i_req_valid[k]=1, searching from the pointer upward with wrap-around.
- o_req_ready is the one-hot grant (combinational), and is zero when no request is valid.
- A handshake completes when valid and ready are both high on a clock edge. On that edge the block latches the operands into o_mul_a/o_mul_b, latches k as the current ID, and moves to ISSUE.
- o_req_ready is 0 in every other state.

ISSUE:
- o_mul_start=1 for exactly this cycle, then the FSM moves to WAIT with the counter cleared.
- o_mul_a/o_mul_b stay stable from ISSUE until the FSM leaves WAIT.

WAIT:
- i_mul_done is sampled only in WAIT; a done pulse in any other state is ignored.
- On i_mul_done=1: capture i_mul_result into o_rsp_result, set o_rsp_error=0, and move to RESP.
- Otherwise the counter increments. When the counter reaches TIMEOUT-1 without done: set o_rsp_result=0, set o_rsp_error=1, and move to RESP.
- If done and timeout occur in the same cycle, done wins.

RESP:
- o_rsp_valid=1, with o_rsp_id, o_rsp_result and o_rsp_error held stable until i_rsp_ready=1.
- On that edge: o_rsp_valid goes to 0, the pointer becomes (ID+1) mod N_REQ, and the FSM returns to IDLE.
- No new grant is made in RESP; backpressure stalls all requesters.

Latency and throughput:
- Handshake edge at cycle t; o_mul_start is high in cycle t+1.
- o_rsp_valid is high in the cycle after the edge on which done is sampled.
- Minimum request-to-request spacing is 4 cycles plus the multiplier latency.

Widths and arithmetic:
- No arithmetic is performed on operands or product; the block is sign-agnostic.
- The counter is $clog2(TIMEOUT+1) bits wide and cannot wrap.

Fairness:
- A requester that holds valid is granted within N_REQ grants.

Test Plan:
- Single request: requester 0 sends a=12, b=13; a multiplier model returns done 34 cycles after start. Required: o_mul_start is high exactly 1 cycle after the handshake; response has o_rsp_result=156, o_rsp_id=0, o_rsp_error=0.
- Simultaneous requests: requesters 0 and 2 raise valid together with the pointer at 0. Required: 0 is served first, then 2. A following request from 0 alone is served next.
- Fairness: all 4 requesters hold valid continuously. Required: grant order is 0,1,2,3,0,1; each o_rsp_id matches its grant; o_req_ready is never more than one-hot.
- Watchdog: the multiplier model never asserts done. Required: exactly TIMEOUT=40 cycles after entering WAIT, o_rsp_valid=1 with o_rsp_error=1 and o_rsp_result=0. A stray done arriving afterwards in IDLE is ignored.
- Backpressure: i_rsp_ready is held low for 5 cycles while o_rsp_valid is high and another request is pending. Required: the response stays stable; o_req_ready stays 0 until the cycle after i_rsp_ready=1.
- Reset mid-WAIT: i_rst_n is asserted low asynchronously between clock edges. Required: all outputs are 0 immediately, state is IDLE, and the pointer is 0. After reset release, requester 3 with a=-4, b=-4 yields o_rsp_result=16 from the model, with o_rsp_id=3.

Source files
------------

// File: rtl/mult_arbiter.sv
// Round-robin front end that shares one sequential multiplier between N_REQ requesters.
// Accepts one operand pair at a time, starts the multiplier, guards it with a watchdog and returns a tagged product.
module mult_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 40,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [N_REQ-1:0]       i_req_valid,
    output logic [N_REQ-1:0]       o_req_ready,
    input  logic [N_REQ*WIDTH-1:0] i_req_a,
    input  logic [N_REQ*WIDTH-1:0] i_req_b,
    output logic                   o_mul_start,
    output logic [WIDTH-1:0]       o_mul_a,
    output logic [WIDTH-1:0]       o_mul_b,
    input  logic                   i_mul_done,
    input  logic [2*WIDTH-1:0]     i_mul_result,
    output logic                   o_rsp_valid,
    output logic [ID_W-1:0]        o_rsp_id,
    output logic [2*WIDTH-1:0]     o_rsp_result,
    output logic                   o_rsp_error,
    input  logic                   i_rsp_ready,
    output logic                   o_busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic               err_q, err_d;

    logic               grant_vld;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W:0]      rr_idx;

    // Scan from the highest offset down so the lowest offset from the pointer wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        rr_idx    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            rr_idx = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (rr_idx >= (ID_W+1)'(N_REQ)) begin
                rr_idx = rr_idx - (ID_W+1)'(N_REQ);
            end
            if (i_req_valid[rr_idx[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = rr_idx[ID_W-1:0];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign o_req_ready[gi] = (state_q == IDLE) && grant_vld && (grant_id == ID_W'(gi));
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    a_d     = i_req_a[int'(grant_id)*WIDTH +: WIDTH];
                    b_d     = i_req_b[int'(grant_id)*WIDTH +: WIDTH];
                    id_d    = grant_id;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A done pulse on the final watchdog cycle still counts as success.
                if (i_mul_done) begin
                    res_d   = i_mul_result;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    ptr_d   = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign o_mul_start  = (state_q == ISSUE);
    assign o_mul_a      = a_q;
    assign o_mul_b      = b_q;
    assign o_rsp_valid  = (state_q == RESP);
    assign o_rsp_id     = id_q;
    assign o_rsp_result = res_q;
    assign o_rsp_error  = err_q;
    assign o_busy       = (state_q != IDLE);

endmodule
